// File: rtl/instruction_fetch.sv
// Fetch stage: owns the program counter, addresses the combinational instruction
// memory and captures each fetched word with its PC+4 into the IF/ID register.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] instr_addr,
    input  logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        addr_fault
);

    localparam logic [29:0] IDX_MASK         = 30'(IMEM_DEPTH - 1);
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
    localparam logic [31:0] NOP              = 32'h0000_0000;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic beyond_imem(input logic [31:0] addr);
        return {2'b00, addr[31:2]} >= 32'(IMEM_DEPTH);
    endfunction

    logic [31:0] pc_p0;
    logic [31:0] pc_plus4_p0;
    logic [31:0] jump_target_p0;
    logic [31:0] target_raw_p0;
    logic [31:0] pc_next_p0;
    logic        redirect_p0;
    logic        misaligned_p0;
    logic        oor_p0;

    logic [31:0] instr_p1;
    logic [31:0] pc_plus4_p1;
    logic        vld_p1;
    logic        fault_q;

    // ---- stage p0: next-PC selection and memory addressing ----
    assign pc_plus4_p0    = pc_p0 + 32'd4;
    // The jump region comes from the PC+4 of the jump itself, now sitting in IF/ID.
    assign jump_target_p0 = {pc_plus4_p1[31:28], jump_index, 2'b00};
    assign redirect_p0    = jump | branch_taken;
    assign target_raw_p0  = jump ? jump_target_p0 : branch_target;
    assign misaligned_p0  = redirect_p0 && (target_raw_p0[1:0] != 2'b00);
    assign oor_p0         = beyond_imem(pc_p0);
    assign instr_addr     = {2'b00, pc_p0[31:2] & IDX_MASK};

    always_comb begin
        pc_next_p0 = pc_plus4_p0;
        if (redirect_p0) begin
            pc_next_p0 = align_word(target_raw_p0);
        end else if (stall) begin
            pc_next_p0 = pc_p0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_p0   <= RESET_PC_ALIGNED;
            fault_q <= 1'b0;
        end else begin
            pc_p0   <= pc_next_p0;
            fault_q <= fault_q | misaligned_p0 | oor_p0;
        end
    end

    // ---- stage p1: IF/ID register ----
    // A redirect squashes the word fetched down the wrong path, costing one bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_p1    <= NOP;
            pc_plus4_p1 <= 32'd0;
            vld_p1      <= 1'b0;
        end else if (flush || redirect_p0) begin
            instr_p1    <= NOP;
            pc_plus4_p1 <= pc_plus4_p0;
            vld_p1      <= 1'b0;
        end else if (!stall) begin
            instr_p1    <= instr;
            pc_plus4_p1 <= pc_plus4_p0;
            vld_p1      <= 1'b1;
        end
    end

    assign pc             = pc_p0;
    assign if_id_instr    = instr_p1;
    assign if_id_pc_plus4 = pc_plus4_p1;
    assign if_id_valid    = vld_p1;
    assign addr_fault     = fault_q;

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage directly upstream of instruction_memory. Holds the program counter and drives the word address into the combinational instruction memory. Captures the returned 32-bit instruction, with PC+4, into an IF/ID pipeline register for the decode stage. Handles stall, flush, branch redirect and jump redirect.

Parameters:
RESET_PC, 32'h0000_0000, byte address loaded into PC on reset; must be word aligned
IMEM_DEPTH, 16, instruction memory depth in 32-bit words; power of two

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
stall  input  1  hold PC and IF/ID contents (load-use hazard from decode)
flush  input  1  squash the instruction being captured into IF/ID
branch_taken  input  1  redirect PC to branch_target next edge
branch_target  input  32  byte address of the taken branch
jump  input  1  redirect PC to the J-format target next edge
jump_index  input  26  instr[25:0] of the jump in decode
instr_addr  output  32  word index to instruction_memory
instr  input  32  instruction from instruction_memory (combinational)
pc  output  32  current fetch PC, byte address
if_id_instr  output  32  registered instruction to decode
if_id_pc_plus4  output  32  registered PC+4 of that instruction
if_id_valid  output  1  IF/ID holds a real instruction
addr_fault  output  1  sticky: misaligned redirect or PC beyond IMEM_DEPTH

Behaviour:
- One clock. Reset is asynchronous and active-low: clk and rst_n, with all state cleared immediately on rst_n low, independent of clk.
- Reset values: pc = RESET_PC; if_id_instr = 0 (NOP); if_id_pc_plus4 = 0; if_id_valid = 0; addr_fault = 0.
- First valid fetch is captured on the first rising edge after rst_n deasserts.
- instr_addr is combinational: {2'b0, pc[31:2]} modulo IMEM_DEPTH, so the upper bits are zeroed. instr is sampled in the same cycle.
- pc_plus4 = pc + 32'd4, which wraps at 2^32 with no flag.
- Jump target = {pc_plus4_of_decode[31:28], jump_index, 2'b00}. The upper bits come from if_id_pc_plus4.
- Next-PC priority at each rising edge, highest first:
  1. jump -> jump target
  2. branch_taken -> branch_target
  3. stall -> pc unchanged
  4. otherwise -> pc_plus4
- A redirect overrides stall: the PC moves even when stall is high.
- IF/ID register update, in priority order:
  - flush, or any redirect: if_id_instr <= 0, if_id_valid <= 0, if_id_pc_plus4 <= pc_plus4. The wrong-path instruction is squashed, so there is one bubble.
  - else stall: all IF/ID fields hold.
  - else: if_id_instr <= instr, if_id_pc_plus4 <= pc_plus4, if_id_valid <= 1.
- Latency: an instruction at PC p appears on if_id_instr at the edge ending the cycle in which pc = p. Redirect penalty is one cycle.
- Misaligned redirect: if the selected target has [1:0] != 0, pc loads the target with [1:0] forced to 00 and addr_fault sets.
- Out of range: if the word index pc[31:2] >= IMEM_DEPTH, addr_fault sets and the fetch still proceeds on the wrapped index.
- addr_fault stays set until reset.
- Simultaneous jump and branch_taken: jump wins. Flush together with stall: the flush wins for IF/ID, and the PC follows the priority list.
- Reset asserted mid-operation: all state returns to reset values immediately. No partial update may survive.

Test Plan:
- Reset with RESET_PC=0 and memory words 0..3 = A,B,C,D, then 4 free-running cycles -> instr_addr 0,1,2,3; if_id_instr A,B,C,D; if_id_pc_plus4 4,8,12,16; if_id_valid rises on the first edge.
- stall high for 2 cycles with pc=8 -> pc holds 8, instr_addr holds 2, IF/ID holds B/8. Fetch resumes with C.
- branch_taken with branch_target=32'h14 while pc=8 -> next pc=0x14, instr_addr=5, and one bubble (if_id_valid=0, if_id_instr=0).
- jump with jump_index=26'h3 and branch_taken=1 in the same cycle -> pc=0x0000000C (jump wins) and addr_fault stays 0.
- branch_target=32'h0000_0006 -> pc=4 and addr_fault=1, still 1 after 10 cycles. With pc advanced to 0x40 (IMEM_DEPTH=16): instr_addr=0 and addr_fault=1.
- rst_n pulsed low between edges while pc=0xC and if_id_valid=1 -> pc=0, if_id_valid=0, if_id_instr=0 before the next edge, and fetch restarts from word 0.
